// File: rtl/resolvedor_noite.sv
// Night-phase resolver: captures werewolf votes and doctor protection, then
// scans the tallies one player per cycle to pick and eliminate the victim.

module resolvedor_noite_voto (
  input  logic       clock,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [2:0] cnt
);
  logic [2:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                      cnt_d = '0;
    else if (inc && cnt_q != 3'd7) cnt_d = cnt_q + 3'd1;
  end

  always_ff @(posedge clock or posedge reset)
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;

  assign cnt = cnt_q;
endmodule

module resolvedor_noite #(
  parameter int N_JOG = 8,
  parameter int W_IDX = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             reinicia_vivos,
  input  logic             limpa,
  input  logic             processar_acao,
  input  logic             confirma,
  input  logic [W_IDX-1:0] jogador,
  input  logic [1:0]       classe,
  input  logic [W_IDX-1:0] alvo,
  input  logic             avaliar,
  output logic             ocupado,
  output logic             pronto,
  output logic             houve_morte,
  output logic [W_IDX-1:0] vitima,
  output logic [N_JOG-1:0] vivos,
  output logic [1:0]       db_estado
);
  localparam int NP = 1 << W_IDX;

  typedef enum logic [1:0] {IDLE = 2'd0, VARRE = 2'd1, DECIDE = 2'd2, PRONTO = 2'd3} estado_t;

  estado_t          estado_q, estado_d;
  logic [W_IDX-1:0] idx_q, idx_d, cand_q, cand_d, protegido_q, protegido_d, vitima_q, vitima_d;
  logic [2:0]       max_q, max_d;
  logic             empate_q, empate_d, prot_valido_q, prot_valido_d, houve_morte_q, houve_morte_d;
  logic [N_JOG-1:0] vivos_q, vivos_d;

  logic             votos_clr, voto_ok, aceita;
  logic [2:0]       v;
  logic [NP-1:0]    vivos_ext;
  logic [NP-1:0][2:0] votos;

  // Padding to the full index range makes out-of-range players read as dead
  // with zero votes, which folds the index bound check into the alive check.
  assign vivos_ext = NP'(vivos_q);
  assign aceita    = processar_acao && confirma && vivos_ext[jogador] && vivos_ext[alvo];

  for (genvar i = 0; i < NP; i++) begin : g_voto
    if (i < N_JOG) begin : g_cnt
      resolvedor_noite_voto u_voto (
        .clock (clock),
        .reset (reset),
        .clr   (votos_clr),
        .inc   (voto_ok && alvo == W_IDX'(i)),
        .cnt   (votos[i])
      );
    end else begin : g_pad
      assign votos[i] = '0;
    end
  end

  always_comb begin
    estado_d      = estado_q;
    idx_d         = idx_q;
    cand_d        = cand_q;
    max_d         = max_q;
    empate_d      = empate_q;
    protegido_d   = protegido_q;
    prot_valido_d = prot_valido_q;
    vivos_d       = vivos_q;
    vitima_d      = vitima_q;
    houve_morte_d = houve_morte_q;
    votos_clr     = 1'b0;
    voto_ok       = 1'b0;
    v             = vivos_ext[idx_q] ? votos[idx_q] : 3'd0;

    if (reinicia_vivos || limpa) begin
      estado_d      = IDLE;
      votos_clr     = 1'b1;
      protegido_d   = '0;
      prot_valido_d = 1'b0;
      vitima_d      = '0;
      houve_morte_d = 1'b0;
      if (reinicia_vivos) vivos_d = '1;
    end else begin
      case (estado_q)
        IDLE: begin
          if (avaliar) begin
            estado_d = VARRE;
            idx_d    = '0;
            max_d    = '0;
            cand_d   = '0;
            empate_d = 1'b0;
          end else if (aceita) begin
            if (classe == 2'd1) voto_ok = 1'b1;
            if (classe == 2'd2) begin
              protegido_d   = alvo;
              prot_valido_d = 1'b1;
            end
          end
        end
        VARRE: begin
          // A new maximum discards any earlier tie; only the final top count matters.
          if (v > max_q) begin
            max_d    = v;
            cand_d   = idx_q;
            empate_d = 1'b0;
          end else if (v == max_q && v != 3'd0) begin
            empate_d = 1'b1;
          end
          if (idx_q == W_IDX'(N_JOG - 1)) estado_d = DECIDE;
          else                            idx_d    = idx_q + W_IDX'(1);
        end
        DECIDE: begin
          estado_d = PRONTO;
          if (max_q != 3'd0 && !empate_q && !(prot_valido_q && protegido_q == cand_q)) begin
            vivos_d[cand_q] = 1'b0;
            vitima_d        = cand_q;
            houve_morte_d   = 1'b1;
          end else begin
            vitima_d      = '0;
            houve_morte_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      estado_q      <= IDLE;
      idx_q         <= '0;
      cand_q        <= '0;
      max_q         <= '0;
      empate_q      <= 1'b0;
      protegido_q   <= '0;
      prot_valido_q <= 1'b0;
      vivos_q       <= '1;
      vitima_q      <= '0;
      houve_morte_q <= 1'b0;
    end else begin
      estado_q      <= estado_d;
      idx_q         <= idx_d;
      cand_q        <= cand_d;
      max_q         <= max_d;
      empate_q      <= empate_d;
      protegido_q   <= protegido_d;
      prot_valido_q <= prot_valido_d;
      vivos_q       <= vivos_d;
      vitima_q      <= vitima_d;
      houve_morte_q <= houve_morte_d;
    end

  assign ocupado     = (estado_q == VARRE) || (estado_q == DECIDE);
  assign pronto      = (estado_q == PRONTO);
  assign houve_morte = houve_morte_q;
  assign vitima      = vitima_q;
  assign vivos       = vivos_q;
  assign db_estado   = estado_q;
endmodule

// File: tb/tb_resolvedor_noite.sv
// Directed bench for resolvedor_noite: table of night scenarios plus
// hand-written sequences for aborts, async reset, saturation and restart.

module tb_resolvedor_noite;
  logic       clock = 1'b0;
  logic       reset, reinicia_vivos, limpa, processar_acao, confirma, avaliar;
  logic [2:0] jogador, alvo, vitima;
  logic [1:0] classe, db_estado;
  logic       ocupado, pronto, houve_morte;
  logic [7:0] vivos;

  int checks = 0;
  int errors = 0;

  resolvedor_noite #(.N_JOG(8), .W_IDX(3)) dut (
    .clock(clock), .reset(reset), .reinicia_vivos(reinicia_vivos), .limpa(limpa),
    .processar_acao(processar_acao), .confirma(confirma), .jogador(jogador),
    .classe(classe), .alvo(alvo), .avaliar(avaliar), .ocupado(ocupado),
    .pronto(pronto), .houve_morte(houve_morte), .vitima(vitima), .vivos(vivos),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit              do_limpa;
    int              nact;
    logic [3:0][8:0] acts;   // {processar_acao, classe, jogador, alvo}
    logic            hm;
    logic [2:0]      vit;
    logic [7:0]      viv;
  } vec_t;

  vec_t vec [7];

  function automatic logic [8:0] mk(input logic p, input logic [1:0] c,
                                    input logic [2:0] j, input logic [2:0] t);
    return {p, c, j, t};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic acao(input logic [8:0] a);
    @(negedge clock);
    processar_acao = a[8]; confirma = 1'b1; classe = a[7:6]; jogador = a[5:3]; alvo = a[2:0];
    @(negedge clock);
    processar_acao = 1'b0; confirma = 1'b0;
  endtask

  task automatic pulse_limpa();
    @(negedge clock); limpa = 1'b1;
    @(negedge clock); limpa = 1'b0;
  endtask

  // Cycles counted from the avaliar cycle itself until pronto is seen.
  task automatic avalia(output int lat, output logic ocup0);
    @(negedge clock); avaliar = 1'b1;
    @(negedge clock); avaliar = 1'b0;
    ocup0 = ocupado;
    lat = 1;
    while (!pronto && lat < 30) begin
      @(negedge clock);
      lat++;
    end
  endtask

  initial begin
    int   lat;
    logic oc;

    vec[0] = '{1'b0, 3, {9'd0, mk(1,2,3,3), mk(1,1,2,5), mk(1,1,1,5)}, 1'b1, 3'd5, 8'hDF};
    vec[1] = '{1'b1, 3, {9'd0, mk(1,2,3,6), mk(1,1,2,6), mk(1,1,1,6)}, 1'b0, 3'd0, 8'hDF};
    vec[2] = '{1'b1, 2, {9'd0, 9'd0, mk(1,1,2,4), mk(1,1,1,2)},        1'b0, 3'd0, 8'hDF};
    vec[3] = '{1'b1, 3, {9'd0, mk(1,1,3,4), mk(1,1,2,4), mk(1,1,1,2)}, 1'b1, 3'd4, 8'hCF};
    vec[4] = '{1'b1, 4, {mk(0,1,1,2), mk(1,0,0,1), mk(1,1,5,1), mk(1,1,1,5)}, 1'b0, 3'd0, 8'hCF};
    vec[5] = '{1'b1, 4, {mk(1,1,3,2), mk(1,1,2,2), mk(1,1,1,1), mk(1,1,0,0)}, 1'b1, 3'd2, 8'hCB};
    vec[6] = '{1'b1, 3, {9'd0, mk(1,2,3,7), mk(1,2,1,6), mk(1,1,0,6)}, 1'b1, 3'd6, 8'h8B};

    reset = 1'b1; reinicia_vivos = 1'b0; limpa = 1'b0; processar_acao = 1'b0;
    confirma = 1'b0; avaliar = 1'b0; jogador = '0; classe = '0; alvo = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;

    chk("rst_estado", 32'(db_estado), 32'd0);
    chk("rst_vivos",  32'(vivos), 32'hFF);
    chk("rst_flags",  {29'd0, pronto, ocupado, houve_morte}, 32'd0);
    chk("rst_vitima", 32'(vitima), 32'd0);

    for (int i = 0; i < 7; i++) begin
      if (vec[i].do_limpa) pulse_limpa();
      for (int a = 0; a < vec[i].nact; a++) acao(vec[i].acts[a]);
      avalia(lat, oc);
      chk($sformatf("v%0d_ocupado", i), 32'(oc), 32'd1);
      chk($sformatf("v%0d_latencia", i), 32'(lat), 32'd10);
      chk($sformatf("v%0d_morte", i), 32'(houve_morte), 32'(vec[i].hm));
      chk($sformatf("v%0d_vitima", i), 32'(vitima), 32'(vec[i].vit));
      chk($sformatf("v%0d_vivos", i), 32'(vivos), 32'(vec[i].viv));
    end

    // PRONTO holds its result against avaliar and confirma
    @(negedge clock); avaliar = 1'b1;
    @(negedge clock); avaliar = 1'b0;
    acao(mk(1,1,0,0));
    repeat (12) @(negedge clock);
    chk("pronto_hold_estado", 32'(db_estado), 32'd3);
    chk("pronto_hold_vitima", 32'(vitima), 32'd6);
    chk("pronto_hold_vivos",  32'(vivos), 32'h8B);

    // limpa mid-scan aborts without touching vivos
    pulse_limpa();
    acao(mk(1,1,0,7));
    @(negedge clock); avaliar = 1'b1;
    @(negedge clock); avaliar = 1'b0;
    repeat (2) @(negedge clock);
    limpa = 1'b1;
    @(negedge clock); limpa = 1'b0;
    chk("abort_estado", 32'(db_estado), 32'd0);
    chk("abort_flags",  {29'd0, pronto, ocupado, houve_morte}, 32'd0);
    chk("abort_vivos",  32'(vivos), 32'h8B);
    repeat (12) @(negedge clock);
    chk("abort_sem_pronto", 32'(pronto), 32'd0);

    // async reset mid-scan takes effect before the next clock edge
    acao(mk(1,1,0,7));
    @(negedge clock); avaliar = 1'b1;
    @(negedge clock); avaliar = 1'b0;
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("areset_estado", 32'(db_estado), 32'd0);
    chk("areset_vivos",  32'(vivos), 32'hFF);
    chk("areset_ocupado", 32'(ocupado), 32'd0);
    @(negedge clock); reset = 1'b0;

    // eight votes on player 0: counter must saturate, not wrap to zero
    for (int j = 1; j < 8; j++) acao(mk(1, 2'd1, 3'(j), 3'd0));
    acao(mk(1,1,1,0));
    avalia(lat, oc);
    chk("sat_latencia", 32'(lat), 32'd10);
    chk("sat_morte",  32'(houve_morte), 32'd1);
    chk("sat_vitima", 32'(vitima), 32'd0);
    chk("sat_vivos",  32'(vivos), 32'hFE);

    @(negedge clock); reinicia_vivos = 1'b1;
    @(negedge clock); reinicia_vivos = 1'b0;
    chk("reinicia_vivos", 32'(vivos), 32'hFF);
    chk("reinicia_estado", 32'(db_estado), 32'd0);
    chk("reinicia_flags", {30'd0, pronto, houve_morte}, 32'd0);
    avalia(lat, oc);
    chk("reinicia_votos_zerados", 32'(houve_morte), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
